// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: TX FIFO, frame sequencing
// and RX hand-off around an external serial engine.
module spi_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol_cfg,
  input  logic                  cpha_cfg,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] eng_rx_data,
  output logic [DATA_WIDTH-1:0] eng_din,
  output logic                  eng_cpol,
  output logic                  eng_cpha,
  output logic                  eng_done_tick,
  output logic                  eng_rst_n,
  output logic                  busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int XN = 2 * DATA_WIDTH;
  localparam int CMAX =
    (XN > GAP_CYCLES) ? XN : GAP_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] X_LAST = CW'(XN - 1);
  localparam logic [CW-1:0] G_LAST =
    CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, XFER, CAPTURE, GAP
  } state_t;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic rxv_q, rxv_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic load_n_q, load_n_d;
  logic push, pop, done_c;

  assign tx_ready = (lvl_q != FULL);
  assign push = tx_valid && tx_ready;
  assign pop = (state_q == IDLE) &&
               (lvl_q != '0);

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) begin
      mem_d[wr_q] = tx_data;
      wr_d = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    lvl_d = lvl_q + LW'(push) - LW'(pop);
  end

  // Frame sequencing and RX hand-off
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    din_d = din_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    load_n_d = 1'b1;
    rxd_d = rxd_q;
    rxv_d = rxv_q && !rx_ready;
    done_c = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          din_d = mem_q[rd_q];
          cpol_d = cpol_cfg;
          cpha_d = cpha_cfg;
          load_n_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        state_d = XFER;
      end
      XFER: begin
        done_c = 1'b0;
        if (cnt_q == X_LAST) begin
          cnt_d = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        if (!rxv_q || rx_ready) begin
          rxd_d = eng_rx_data;
          rxv_d = 1'b1;
          cnt_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
      rxd_q <= '0;
      rxv_q <= 1'b0;
      din_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      load_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      rxd_q <= rxd_d;
      rxv_q <= rxv_d;
      din_q <= din_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      load_n_q <= load_n_d;
    end
  end

  assign rx_data = rxd_q;
  assign rx_valid = rxv_q;
  assign eng_din = din_q;
  assign eng_cpol = cpol_q;
  assign eng_cpha = cpha_q;
  assign eng_done_tick = done_c;
  assign eng_rst_n = rst_n && load_n_q;
  assign busy = (state_q != IDLE);
  assign tx_level = lvl_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: vector table
// plus hand sequences for multi-cycle corners.
module tb_spi_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol_cfg = 1'b0;
  logic cpha_cfg = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready = 1'b0;
  logic [7:0] eng_rx_data;
  logic [7:0] eng_din;
  logic eng_cpol, eng_cpha;
  logic eng_done_tick, eng_rst_n, busy;
  logic [2:0] tx_level;

  int nvec = 0;
  int nbad = 0;
  int cyc = 0;
  int lowcnt = 0;

  spi_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpol_cfg(cpol_cfg), .cpha_cfg(cpha_cfg),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .eng_rx_data(eng_rx_data),
    .eng_din(eng_din),
    .eng_cpol(eng_cpol), .eng_cpha(eng_cpha),
    .eng_done_tick(eng_done_tick),
    .eng_rst_n(eng_rst_n),
    .busy(busy), .tx_level(tx_level)
  );

  // Stand-in engine: returns the inverted word
  assign eng_rx_data = eng_din ^ 8'hFF;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!eng_done_tick) lowcnt <= lowcnt + 1;

  typedef struct {
    int adv;
    logic busy, done, ern, rxv;
    logic [2:0] lvl;
    logic [7:0] din, rxd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [7:0] d);
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_load(string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!eng_rst_n) ok = 1'b1;
    end
    chk({nm, " load seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk({nm, " idle seen"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    cpol_cfg = 1'b0;
    cpha_cfg = 1'b0;
    rx_ready = 1'b0;
    step(2);
    chk("rst done", 32'(eng_done_tick), 32'd1);
    chk("rst ern", 32'(eng_rst_n), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst lvl", 32'(tx_level), 32'd0);
    chk("rst rxv", 32'(rx_valid), 32'd0);
    chk("rst din", 32'(eng_din), 32'd0);
    chk("rst rdy", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 1, 0, 3'd1, 8'h00, 8'h00};
    tbl[1] = '{1, 1, 1, 0, 0, 3'd0, 8'hA5, 8'h00};
    tbl[2] = '{1, 1, 0, 1, 0, 3'd0, 8'hA5, 8'h00};
    tbl[3] = '{15, 1, 0, 1, 0, 3'd0, 8'hA5, 8'h00};
    tbl[4] = '{1, 1, 1, 1, 0, 3'd0, 8'hA5, 8'h00};
    tbl[5] = '{1, 1, 1, 1, 1, 3'd0, 8'hA5, 8'h5A};
    tbl[6] = '{1, 1, 1, 1, 1, 3'd0, 8'hA5, 8'h5A};
    tbl[7] = '{1, 0, 1, 1, 1, 3'd0, 8'hA5, 8'h5A};
    tbl[8] = '{1, 0, 1, 1, 1, 3'd0, 8'hA5, 8'h5A};

    // single frame, mode 0
    do_reset();
    begin
      int lc0;
      lc0 = lowcnt;
      push(8'hA5);
      for (int i = 0; i < 9; i++) begin
        step(tbl[i].adv);
        chk($sformatf("v%0d busy", i),
            32'(busy), 32'(tbl[i].busy));
        chk($sformatf("v%0d done", i),
            32'(eng_done_tick), 32'(tbl[i].done));
        chk($sformatf("v%0d ern", i),
            32'(eng_rst_n), 32'(tbl[i].ern));
        chk($sformatf("v%0d rxv", i),
            32'(rx_valid), 32'(tbl[i].rxv));
        chk($sformatf("v%0d lvl", i),
            32'(tx_level), 32'(tbl[i].lvl));
        chk($sformatf("v%0d din", i),
            32'(eng_din), 32'(tbl[i].din));
        chk($sformatf("v%0d rxd", i),
            32'(rx_data), 32'(tbl[i].rxd));
      end
      chk("done low cycles", 32'(lowcnt - lc0),
          32'd16);
      rx_ready = 1'b1;
      step(1);
      chk("rx consumed", 32'(rx_valid), 32'd0);
    end

    // fill FIFO during a frame, order + spacing
    do_reset();
    rx_ready = 1'b1;
    begin
      int t0;
      logic [7:0] w [5];
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
      w[3] = 8'h44; w[4] = 8'h55;
      push(w[0]);
      wait_load("f0");
      t0 = cyc;
      chk("f0 din", 32'(eng_din), 32'(w[0]));
      step(2);
      for (int i = 1; i < 5; i++) push(w[i]);
      chk("full rdy", 32'(tx_ready), 32'd0);
      chk("full lvl", 32'(tx_level), 32'd4);
      push(8'h99);
      chk("ovf lvl", 32'(tx_level), 32'd4);
      for (int k = 1; k < 5; k++) begin
        wait_load($sformatf("f%0d", k));
        chk($sformatf("f%0d din", k),
            32'(eng_din), 32'(w[k]));
        chk($sformatf("f%0d gap", k),
            32'(cyc - t0), 32'(21 * k));
      end
      step(30);
      chk("no 5th frame", 32'(busy), 32'd0);
      chk("drained", 32'(tx_level), 32'd0);
    end

    // CAPTURE stall with rx_ready low
    do_reset();
    push(8'h5A);
    push(8'hC3);
    wait_load("stall B");
    chk("A held", 32'(rx_data), 32'hA5);
    chk("A valid", 32'(rx_valid), 32'd1);
    step(17);
    step(5);
    chk("stall busy", 32'(busy), 32'd1);
    chk("stall done", 32'(eng_done_tick), 32'd1);
    chk("stall rxd", 32'(rx_data), 32'hA5);
    chk("stall rxv", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    step(1);
    chk("B reload", 32'(rx_data), 32'h3C);
    chk("B valid", 32'(rx_valid), 32'd1);
    step(1);
    chk("B taken", 32'(rx_valid), 32'd0);

    // cfg change mid-frame
    do_reset();
    rx_ready = 1'b1;
    push(8'h77);
    wait_load("cfg f0");
    chk("cfg0 cpol", 32'(eng_cpol), 32'd0);
    chk("cfg0 cpha", 32'(eng_cpha), 32'd0);
    step(3);
    cpol_cfg = 1'b1;
    cpha_cfg = 1'b1;
    step(4);
    chk("mid cpol", 32'(eng_cpol), 32'd0);
    chk("mid cpha", 32'(eng_cpha), 32'd0);
    push(8'h88);
    wait_load("cfg f1");
    chk("cfg1 cpol", 32'(eng_cpol), 32'd1);
    chk("cfg1 cpha", 32'(eng_cpha), 32'd1);
    chk("cfg1 din", 32'(eng_din), 32'h88);

    // async reset in XFER cycle 7
    do_reset();
    rx_ready = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("xfer start", 32'(eng_done_tick), 32'd0);
    chk("pre lvl", 32'(tx_level), 32'd2);
    step(7);
    #1 rst_n = 1'b0;
    #1;
    chk("abort done", 32'(eng_done_tick), 32'd1);
    chk("abort ern", 32'(eng_rst_n), 32'd0);
    chk("abort lvl", 32'(tx_level), 32'd0);
    chk("abort rxv", 32'(rx_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("post busy", 32'(busy), 32'd0);
    chk("post ern", 32'(eng_rst_n), 32'd1);

    // push and pop in the same cycle at level 2
    do_reset();
    rx_ready = 1'b1;
    push(8'h10);
    wait_load("pp f0");
    step(2);
    push(8'h20);
    push(8'h30);
    wait_idle("pp");
    chk("pp lvl before", 32'(tx_level), 32'd2);
    push(8'h40);
    chk("pp lvl after", 32'(tx_level), 32'd2);
    chk("pp load", 32'(eng_rst_n), 32'd0);
    chk("pp din1", 32'(eng_din), 32'h20);
    wait_load("pp f2");
    chk("pp din2", 32'(eng_din), 32'h30);
    wait_load("pp f3");
    chk("pp din3", 32'(eng_din), 32'h40);
    chk("pp empty", 32'(tx_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
